// File: rtl/cp0_regfile_if.sv
// MTC0/MFC0 access bus between the pipeline and the CP0 register file.
interface cp0_regfile_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;

    modport master (
        output we_i,
        output waddr_i,
        output data_i,
        output raddr_i,
        input  data_o
    );

    modport slave (
        input  we_i,
        input  waddr_i,
        input  data_i,
        input  raddr_i,
        output data_o
    );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC plus exception
// entry/return handling and pipeline redirect.
// Optional timer interrupt is compiled in by defining CP0_TIMER_INT_EN.
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic         clk,
    input  logic         resetn,
    cp0_regfile_if.slave bus,
    input  logic [5:0]   int_i,
    input  logic [31:0]  excepttype_i,
    input  logic [31:0]  current_inst_addr_i,
    input  logic         is_in_delayslot_i,
    input  logic [31:0]  bad_addr_i,
    output logic [31:0]  status_o,
    output logic [31:0]  cause_o,
    output logic [31:0]  epc_o,
    output logic [31:0]  badvaddr_o,
    output logic [31:0]  count_o,
    output logic [31:0]  compare_o,
    output logic         timer_int_o,
    output logic         flush_o,
    output logic [31:0]  newpc_o
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam logic [AW-1:0] REG_BADVADDR = AW'(8);
    localparam logic [AW-1:0] REG_COUNT    = AW'(9);
    localparam logic [AW-1:0] REG_COMPARE  = AW'(11);
    localparam logic [AW-1:0] REG_STATUS   = AW'(12);
    localparam logic [AW-1:0] REG_CAUSE    = AW'(13);
    localparam logic [AW-1:0] REG_EPC      = AW'(14);

    localparam logic [DW-1:0] EXC_ERET = DW'(32'hE);

    // Architectural state
    logic [DW-1:0] badvaddr_q, badvaddr_d;
    logic [DW-1:0] count_q,    count_d;
    logic [DW-1:0] compare_q,  compare_d;
    logic [DW-1:0] epc_q,      epc_d;
    logic [7:0]    im_q,       im_d;
    logic          exl_q,      exl_d;
    logic          ie_q,       ie_d;
    logic          bd_q,       bd_d;
    logic [1:0]    ip_sw_q,    ip_sw_d;
    logic [5:0]    ip_hw_q,    ip_hw_d;
    logic [4:0]    exccode_q,  exccode_d;
    logic          tick_q,     tick_d;

    logic          exc_any_c;
    logic          exc_eret_c;
    logic          exc_take_c;
    logic          code_valid_c;
    logic [4:0]    code_c;
    logic          wr_compare_c;

    assign exc_any_c    = (excepttype_i != '0);
    assign exc_eret_c   = (excepttype_i == EXC_ERET);
    assign exc_take_c   = exc_any_c && !exc_eret_c;
    assign wr_compare_c = bus.we_i && (bus.waddr_i == REG_COMPARE);

    // Map exception type to ExcCode; unlisted codes leave ExcCode alone
    always_comb begin
        code_valid_c = 1'b1;
        code_c       = 5'd0;
        case (excepttype_i)
            32'h1:   code_c = 5'd0;
            32'h4:   code_c = 5'd4;
            32'h5:   code_c = 5'd5;
            32'h8:   code_c = 5'd8;
            32'h9:   code_c = 5'd9;
            32'hA:   code_c = 5'd10;
            32'hC:   code_c = 5'd12;
            default: code_valid_c = 1'b0;
        endcase
    end

    // Next-state: MTC0 first, exception updates override the fields they own
    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q + DW'(tick_q);
        compare_d  = compare_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = int_i;
        exccode_d  = exccode_q;
        tick_d     = ~tick_q;

        if (bus.we_i) begin
            case (bus.waddr_i)
                REG_COUNT: begin
                    count_d = bus.data_i;
                    tick_d  = 1'b0;
                end
                REG_COMPARE: compare_d = bus.data_i;
                REG_STATUS: begin
                    im_d  = bus.data_i[15:8];
                    exl_d = bus.data_i[1];
                    ie_d  = bus.data_i[0];
                end
                REG_CAUSE: ip_sw_d = bus.data_i[9:8];
                REG_EPC:   epc_d   = bus.data_i;
                default: ;
            endcase
        end

        if (exc_take_c) begin
            exl_d = 1'b1;
            if (!exl_q) begin
                epc_d = is_in_delayslot_i ? (current_inst_addr_i - DW'(4))
                                          : current_inst_addr_i;
                bd_d  = is_in_delayslot_i;
            end
            if (code_valid_c) begin
                exccode_d = code_c;
            end
            if ((excepttype_i == 32'h4) || (excepttype_i == 32'h5)) begin
                badvaddr_d = bad_addr_i;
            end
        end else if (exc_eret_c) begin
            exl_d = 1'b0;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            exccode_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            exccode_q  <= exccode_d;
            tick_q     <= tick_d;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic timer_int_q;

    // Timer interrupt: set on Count==Compare (Compare nonzero), cleared by writing Compare
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_int_q <= 1'b0;
        end else if (wr_compare_c) begin
            timer_int_q <= 1'b0;
        end else if ((compare_q != '0) && (count_q == compare_q)) begin
            timer_int_q <= 1'b1;
        end
    end

    assign timer_int_o = timer_int_q;
`else
    logic unused_wr_compare;
    assign unused_wr_compare = wr_compare_c;
    assign timer_int_o       = 1'b0;
`endif

    // Register views; BEV is hardwired to 1
    assign status_o   = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_o    = {bd_q, 15'd0, ip_hw_q[5] | timer_int_o, ip_hw_q[4:0],
                         ip_sw_q, 1'b0, exccode_q, 2'd0};
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;
    assign count_o    = count_q;
    assign compare_o  = compare_q;

    // MFC0 read port returns pre-edge register contents
    always_comb begin
        bus.data_o = '0;
        case (bus.raddr_i)
            REG_BADVADDR: bus.data_o = badvaddr_q;
            REG_COUNT:    bus.data_o = count_q;
            REG_COMPARE:  bus.data_o = compare_q;
            REG_STATUS:   bus.data_o = status_o;
            REG_CAUSE:    bus.data_o = cause_o;
            REG_EPC:      bus.data_o = epc_q;
            default:      bus.data_o = '0;
        endcase
    end

    // Same-cycle flush and redirect
    always_comb begin
        flush_o = exc_any_c;
        newpc_o = '0;
        if (exc_eret_c) begin
            newpc_o = epc_q;
        end else if (exc_any_c) begin
            newpc_o = EXC_VECTOR;
        end
    end

endmodule
